// File: rtl/wb_periph_hub.sv
// rtl/wb_periph_hub.sv - Wishbone one-to-N peripheral hub with interrupt aggregation.
// Optional ack timeout enabled by defining WB_PERIPH_HUB_TIMEOUT_EN.
module wb_periph_hub #(
  parameter int N_CH   = 2,
  parameter int DW     = 8,
  parameter int SADR_W = 3,
  parameter int TO_CYC = 255,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic [CH_W+SADR_W-1:0] adr_i,
  input  logic                 we_i,
  input  logic [DW-1:0]        dat_i,
  output logic [DW-1:0]        dat_o,
  output logic                 ack_o,
  output logic                 err_o,
  output logic                 inta_o,
  output logic [CH_W-1:0]      int_src_o,
  input  logic [N_CH-1:0]      int_mask_i,
  output logic                 s_cyc_o,
  output logic [N_CH-1:0]      s_stb_o,
  output logic [SADR_W-1:0]    s_adr_o,
  output logic                 s_we_o,
  output logic [DW-1:0]        s_dat_o,
  input  logic [N_CH*DW-1:0]   s_dat_i,
  input  logic [N_CH-1:0]      s_ack_i,
  input  logic [N_CH-1:0]      s_inta_i
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                s_cyc_q, s_cyc_d;
  logic [N_CH-1:0]     s_stb_q, s_stb_d;
  logic [SADR_W-1:0]   s_adr_q, s_adr_d;
  logic                s_we_q, s_we_d;
  logic [DW-1:0]       s_dat_q, s_dat_d;
  logic [DW-1:0]       dat_q, dat_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [N_CH-1:0]     pend_q, pend_d;
  logic [CH_W-1:0]     int_src;

  logic [CH_W-1:0]     req_ch;
  logic                ch_ok;
  logic                sel_ack;
  logic [DW-1:0]       sel_dat;
  logic                to_expire;

  assign req_ch  = adr_i[CH_W+SADR_W-1:SADR_W];
  assign ch_ok   = (int'(req_ch) < N_CH);
  assign sel_ack = s_ack_i[ch_q];
  assign sel_dat = s_dat_i[int'(ch_q)*DW +: DW];

`ifdef WB_PERIPH_HUB_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;

  // Expiry is flagged one count early so err_o lands TO_CYC cycles after the strobe rises.
  assign to_expire = (to_cnt_q == 16'(TO_CYC - 1));

  always_comb begin
    to_cnt_d = '0;
    if (state_q == ACTIVE && !sel_ack) to_cnt_d = to_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  assign to_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    s_cyc_d = s_cyc_q;
    s_stb_d = s_stb_q;
    s_adr_d = s_adr_q;
    s_we_d  = s_we_q;
    s_dat_d = s_dat_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A request still held during the error cycle is not re-evaluated.
        if (cyc_i && stb_i && !err_q) begin
          if (ch_ok) begin
            ch_d    = req_ch;
            s_cyc_d = 1'b1;
            for (int k = 0; k < N_CH; k++) s_stb_d[k] = (int'(req_ch) == k);
            s_adr_d = adr_i[SADR_W-1:0];
            s_we_d  = we_i;
            s_dat_d = dat_i;
            state_d = ACTIVE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!cyc_i) begin
          s_cyc_d = 1'b0;
          s_stb_d = '0;
          state_d = IDLE;
        end else if (sel_ack) begin
          dat_d   = sel_dat;
          ack_d   = 1'b1;
          s_cyc_d = 1'b0;
          s_stb_d = '0;
          state_d = RESP;
        end else if (to_expire) begin
          err_d   = 1'b1;
          s_cyc_d = 1'b0;
          s_stb_d = '0;
          state_d = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pend_d = s_inta_i & int_mask_i;

  always_comb begin
    int_src = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (pend_q[k]) int_src = CH_W'(k);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ch_q    <= '0;
      s_cyc_q <= 1'b0;
      s_stb_q <= '0;
      s_adr_q <= '0;
      s_we_q  <= 1'b0;
      s_dat_q <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      s_cyc_q <= s_cyc_d;
      s_stb_q <= s_stb_d;
      s_adr_q <= s_adr_d;
      s_we_q  <= s_we_d;
      s_dat_q <= s_dat_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign dat_o     = dat_q;
  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign inta_o    = |pend_q;
  assign int_src_o = int_src;
  assign s_cyc_o   = s_cyc_q;
  assign s_stb_o   = s_stb_q;
  assign s_adr_o   = s_adr_q;
  assign s_we_o    = s_we_q;
  assign s_dat_o   = s_dat_q;

endmodule

// File: tb/tb_wb_periph_hub.sv
// tb/tb_wb_periph_hub.sv - Randomized self-checking bench for wb_periph_hub (N_CH=3, TO_CYC=4).
module tb_wb_periph_hub;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cyc_i = 1'b0;
  logic        stb_i = 1'b0;
  logic [4:0]  adr_i = '0;
  logic        we_i = 1'b0;
  logic [7:0]  dat_i = '0;
  logic [7:0]  dat_o;
  logic        ack_o;
  logic        err_o;
  logic        inta_o;
  logic [1:0]  int_src_o;
  logic [2:0]  int_mask_i = '0;
  logic        s_cyc_o;
  logic [2:0]  s_stb_o;
  logic [2:0]  s_adr_o;
  logic        s_we_o;
  logic [7:0]  s_dat_o;
  logic [23:0] s_dat_i = '0;
  logic [2:0]  s_ack_i = '0;
  logic [2:0]  s_inta_i = '0;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_dat = 8'h00;

  wb_periph_hub #(.N_CH(3), .DW(8), .SADR_W(3), .TO_CYC(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .adr_i(adr_i),
    .we_i(we_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o),
    .inta_o(inta_o), .int_src_o(int_src_o), .int_mask_i(int_mask_i),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_we_o(s_we_o),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_inta_i(s_inta_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One master transaction; hostile makes every other channel ack with 0xFF data.
  task automatic do_txn(input int ch, input logic we, input logic [2:0] la, input logic [7:0] wd,
                        input int waits, input logic [7:0] rd, input bit hostile);
    logic [2:0] exp_stb;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = {2'(ch), la}; dat_i = wd; s_ack_i = '0;
    step();
    if (ch >= 3) begin
      total++;
      if ({err_o, ack_o, s_cyc_o, s_stb_o} !== 6'b100000) begin
        bad++; $display("FAIL bad_channel_err got=%b exp=100000", {err_o, ack_o, s_cyc_o, s_stb_o});
      end
      cyc_i = 1'b0; stb_i = 1'b0;
      step();
      total++;
      if ({err_o, ack_o, s_stb_o} !== 5'b0 || dat_o !== exp_dat) begin
        bad++; $display("FAIL bad_channel_after got=%b dat=%h exp=00000 dat=%h", {err_o, ack_o, s_stb_o}, dat_o, exp_dat);
      end
      return;
    end
    exp_stb = 3'(1 << ch);
    for (int w = 0; w <= waits; w++) begin
      total++;
      if ({s_cyc_o, s_stb_o, s_adr_o, s_we_o, s_dat_o, ack_o, err_o} !== {1'b1, exp_stb, la, we, wd, 2'b00}) begin
        bad++;
        $display("FAIL active_hold ch=%0d w=%0d got=%h exp=%h", ch, w,
                 {s_cyc_o, s_stb_o, s_adr_o, s_we_o, s_dat_o, ack_o, err_o}, {1'b1, exp_stb, la, we, wd, 2'b00});
      end
      s_dat_i = hostile ? 24'hFFFFFF : 24'($urandom);
      s_ack_i = hostile ? ~exp_stb : (3'($urandom) & ~exp_stb);
      if (w == waits) begin
        s_ack_i = s_ack_i | exp_stb;
        s_dat_i[ch*8 +: 8] = rd;
      end
      step();
    end
    s_ack_i = '0; cyc_i = 1'b0; stb_i = 1'b0;
    exp_dat = rd;
    total++;
    if ({ack_o, err_o, s_cyc_o, s_stb_o} !== 6'b100000 || dat_o !== exp_dat) begin
      bad++; $display("FAIL resp ch=%0d got=%b dat=%h exp=100000 dat=%h", ch, {ack_o, err_o, s_cyc_o, s_stb_o}, dat_o, exp_dat);
    end
    step();
    total++;
    if ({ack_o, err_o, s_cyc_o} !== 3'b000 || dat_o !== exp_dat) begin
      bad++; $display("FAIL after_resp got=%b dat=%h exp=000 dat=%h", {ack_o, err_o, s_cyc_o}, dat_o, exp_dat);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if ({dat_o, ack_o, err_o, inta_o, int_src_o, s_cyc_o, s_stb_o, s_adr_o, s_we_o, s_dat_o} !== 32'h0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {dat_o, ack_o, err_o, inta_o, int_src_o, s_cyc_o, s_stb_o, s_adr_o, s_we_o, s_dat_o});
    end
    rst_i = 1'b0;
    step();
    total++;
    if ({ack_o, err_o, s_cyc_o, s_stb_o} !== 6'b0) begin
      bad++; $display("FAIL post_reset_idle got=%b exp=0", {ack_o, err_o, s_cyc_o, s_stb_o});
    end
  endtask

  task automatic test_directed();
    do_txn(1, 1'b1, 3'b010, 8'h5A, 0, 8'h11, 1'b0);
    do_txn(0, 1'b0, 3'b101, 8'h00, 3, 8'hC3, 1'b1);
    do_txn(3, 1'b0, 3'b001, 8'h77, 0, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    repeat (40) begin
      do_txn($urandom_range(0, 3), 1'($urandom), 3'($urandom), 8'($urandom),
             $urandom_range(0, 2), 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_abort();
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = {2'd2, 3'd5}; dat_i = 8'h3C;
    step();
    step();
    total++;
    if ({s_cyc_o, s_stb_o} !== 4'b1100) begin
      bad++; $display("FAIL abort_active got=%b exp=1100", {s_cyc_o, s_stb_o});
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({s_cyc_o, s_stb_o, ack_o, err_o} !== 6'b0 || dat_o !== exp_dat) begin
        bad++; $display("FAIL abort_quiet i=%0d got=%b dat=%h exp=0 dat=%h", i, {s_cyc_o, s_stb_o, ack_o, err_o}, dat_o, exp_dat);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = {2'd1, 3'd6}; dat_i = 8'hA5;
    step();
    step();
    #2;
    rst_i = 1'b1;
    #1;
    exp_dat = 8'h00;
    total++;
    if ({dat_o, ack_o, err_o, inta_o, int_src_o, s_cyc_o, s_stb_o, s_adr_o, s_we_o, s_dat_o} !== 32'h0) begin
      bad++; $display("FAIL reset_mid got=%h exp=0", {dat_o, ack_o, err_o, inta_o, int_src_o, s_cyc_o, s_stb_o, s_adr_o, s_we_o, s_dat_o});
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    step();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({ack_o, err_o, s_cyc_o, s_stb_o} !== 6'b0) begin
        bad++; $display("FAIL reset_mid_quiet i=%0d got=%b exp=0", i, {ack_o, err_o, s_cyc_o, s_stb_o});
      end
    end
  endtask

  task automatic test_timeout();
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = {2'd0, 3'd1}; dat_i = 8'h00;
    step();
`ifdef WB_PERIPH_HUB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({s_stb_o, err_o, ack_o} !== 5'b00100) begin
        bad++; $display("FAIL timeout_wait i=%0d got=%b exp=00100", i, {s_stb_o, err_o, ack_o});
      end
      step();
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    total++;
    if ({s_cyc_o, s_stb_o, err_o, ack_o} !== 6'b000010) begin
      bad++; $display("FAIL timeout_err got=%b exp=000010", {s_cyc_o, s_stb_o, err_o, ack_o});
    end
    step();
    total++;
    if ({err_o, ack_o} !== 2'b00) begin
      bad++; $display("FAIL timeout_pulse got=%b exp=00", {err_o, ack_o});
    end
`else
    repeat (300) step();
    total++;
    if ({s_cyc_o, s_stb_o, err_o, ack_o} !== 6'b100100) begin
      bad++; $display("FAIL no_timeout_hold got=%b exp=100100", {s_cyc_o, s_stb_o, err_o, ack_o});
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    step();
    total++;
    if ({s_cyc_o, s_stb_o} !== 4'b0) begin
      bad++; $display("FAIL no_timeout_abort got=%b exp=0", {s_cyc_o, s_stb_o});
    end
`endif
    do_txn(2, 1'b0, 3'd7, 8'h00, 1, 8'h9E, 1'b0);
  endtask

  task automatic test_irq();
    logic [2:0] p;
    logic [1:0] src;
    s_inta_i = 3'b110; int_mask_i = 3'b011;
    step();
    total++;
    if ({inta_o, int_src_o} !== 3'b101) begin
      bad++; $display("FAIL irq_directed_a got=%b exp=101", {inta_o, int_src_o});
    end
    int_mask_i = 3'b001;
    step();
    total++;
    if ({inta_o, int_src_o} !== 3'b000) begin
      bad++; $display("FAIL irq_directed_b got=%b exp=000", {inta_o, int_src_o});
    end
    repeat (20) begin
      s_inta_i = 3'($urandom); int_mask_i = 3'($urandom);
      p = s_inta_i & int_mask_i;
      src = 2'd0;
      for (int k = 0; k < 3; k++) begin
        if (p[k]) begin
          src = 2'(k);
          break;
        end
      end
      step();
      total++;
      if ({inta_o, int_src_o} !== {(p != 3'b0), src}) begin
        bad++; $display("FAIL irq_random pend=%b got=%b exp=%b", p, {inta_o, int_src_o}, {(p != 3'b0), src});
      end
    end
    s_inta_i = '0; int_mask_i = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_timeout();
    test_irq();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
